contador_display: RTL and testbench

Downstream consumer of the 4-bit bouncing up/down counter. It samples the counter value every clock and classifies each change as up step, down step, hold or illegal jump. It tracks sweep direction and counts reversals. It also drives a two-digit multiplexed 7-segment display showing the value in decimal (0–15).

---
 rtl/contador_display.sv | 172 +++++++++++++++++
 tb/tb_contador_display.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_display.sv
// contador_display: watches a 4-bit bouncing counter. Each change is classified
// as an up step, down step, hold or illegal jump. The block tracks the sweep
// direction, counts reversals, and drives a two-digit multiplexed decimal
// 7-segment display of the sampled value.
module contador_display #(
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       CLK,
   input  logic       R,
   input  logic [3:0] I,
   output logic [6:0] SEG,
   output logic [1:0] AN,
   output logic       DIR,
   output logic       HOLD,
   output logic [7:0] TURNS,
   output logic       ERR
);

   localparam int            CW      = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] TC      = CW'(REFRESH_DIV - 1);
   localparam logic [6:0]    SEG_POL = {7{SEG_ACTIVE_LOW}};
   localparam logic [1:0]    AN_POL  = {2{SEG_ACTIVE_LOW}};

   // Active-high segment pattern for one decimal digit (bit0=a .. bit6=g)
   function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h00;
      endcase
      return pat;
   endfunction

   logic [3:0]    i_q_r;
   logic          primed_r;
   logic          stepped_r;
   logic          dir_r;
   logic          hold_r;
   logic [7:0]    turns_r;
   logic          err_r;
   logic [CW-1:0] refresh_r;
   logic          ds_r;
   logic [6:0]    seg_r;
   logic [1:0]    an_r;

   logic [3:0]    inc_s;
   logic [3:0]    dec_s;
   logic          is_up_s;
   logic          is_down_s;
   logic          is_hold_s;
   logic          is_jump_s;
   logic          tens_s;
   logic [3:0]    units_s;
   logic [6:0]    seg_next_s;

   // Neighbours of the previous sample, wrapping mod 16
   assign inc_s = i_q_r + 4'd1;
   assign dec_s = i_q_r - 4'd1;

   // Classify the new sample against the previous one once primed
   always_comb begin
      is_up_s   = 1'b0;
      is_down_s = 1'b0;
      is_hold_s = 1'b0;
      is_jump_s = 1'b0;
      if (primed_r) begin
         if (I == inc_s) begin
            is_up_s = 1'b1;
         end else if (I == dec_s) begin
            is_down_s = 1'b1;
         end else if (I == i_q_r) begin
            is_hold_s = 1'b1;
         end else begin
            is_jump_s = 1'b1;
         end
      end else begin
         is_up_s = 1'b0;
      end
   end

   // Sample register, direction tracking, reversal count and sticky error
   always_ff @(posedge CLK) begin
      if (R) begin
         i_q_r     <= 4'd0;
         primed_r  <= 1'b0;
         stepped_r <= 1'b0;
         dir_r     <= 1'b0;
         hold_r    <= 1'b0;
         turns_r   <= 8'd0;
         err_r     <= 1'b0;
      end else begin
         i_q_r    <= I;
         primed_r <= 1'b1;
         hold_r   <= is_hold_s;
         if (is_jump_s) begin
            err_r <= 1'b1;
         end
         if (is_up_s || is_down_s) begin
            stepped_r <= 1'b1;
            if (!stepped_r) begin
               // first step only establishes the direction
               dir_r <= is_down_s;
            end else if (is_down_s != dir_r) begin
               dir_r <= is_down_s;
               if (turns_r != 8'd255) begin
                  turns_r <= turns_r + 8'd1;
               end
            end
         end
      end
   end

   // Refresh timer: each digit slot lasts REFRESH_DIV cycles
   always_ff @(posedge CLK) begin
      if (R) begin
         refresh_r <= {CW{1'b0}};
         ds_r      <= 1'b0;
      end else if (refresh_r == TC) begin
         refresh_r <= {CW{1'b0}};
         ds_r      <= ~ds_r;
      end else begin
         refresh_r <= refresh_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Split the sample into decimal digits
   assign tens_s  = (i_q_r >= 4'd10);
   assign units_s = tens_s ? (i_q_r - 4'd10) : i_q_r;

   // Select the pattern for the active digit, blanking a leading zero
   always_comb begin
      seg_next_s = 7'h00;
      if (ds_r) begin
         if (tens_s) begin
            seg_next_s = seg_pattern(4'd1);
         end else begin
            seg_next_s = 7'h00;
         end
      end else begin
         seg_next_s = seg_pattern(units_s);
      end
   end

   // Registered display drive with polarity applied
   always_ff @(posedge CLK) begin
      if (R) begin
         seg_r <= SEG_POL;
         an_r  <= AN_POL;
      end else begin
         seg_r <= seg_next_s ^ SEG_POL;
         an_r  <= (ds_r ? 2'b10 : 2'b01) ^ AN_POL;
      end
   end

   assign SEG   = seg_r;
   assign AN    = an_r;
   assign DIR   = dir_r;
   assign HOLD  = hold_r;
   assign TURNS = turns_r;
   assign ERR   = err_r;

endmodule

// File: tb/tb_contador_display.sv
// tb_contador_display: drives two display variants (active-high, div 4 and
// active-low, div 5) with directed and random counter streams and checks every
// output each cycle against a behavioural model.
module tb_contador_display;

   localparam int DIV_A = 4;
   localparam int DIV_B = 5;

   logic       CLK = 1'b0;
   logic       R   = 1'b1;
   logic [3:0] I   = 4'd0;
   logic [6:0] SEG_a, SEG_b;
   logic [1:0] AN_a, AN_b;
   logic       DIR_a, DIR_b, HOLD_a, HOLD_b, ERR_a, ERR_b;
   logic [7:0] TURNS_a, TURNS_b;

   contador_display #(.REFRESH_DIV(DIV_A), .SEG_ACTIVE_LOW(1'b0)) dut_a (
      .CLK(CLK), .R(R), .I(I), .SEG(SEG_a), .AN(AN_a), .DIR(DIR_a),
      .HOLD(HOLD_a), .TURNS(TURNS_a), .ERR(ERR_a));

   contador_display #(.REFRESH_DIV(DIV_B), .SEG_ACTIVE_LOW(1'b1)) dut_b (
      .CLK(CLK), .R(R), .I(I), .SEG(SEG_b), .AN(AN_b), .DIR(DIR_b),
      .HOLD(HOLD_b), .TURNS(TURNS_b), .ERR(ERR_b));

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;

   logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // behavioural model state
   int         m_n;      // edges since the reset edge
   bit         m_valid;  // a previous sample exists
   int         m_iq;
   bit         m_stepped, m_dir, m_hold, m_err;
   int         m_turns;
   logic [6:0] e_seg_a, e_seg_b;
   logic [1:0] e_an_a, e_an_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] digit_seg(input int iq, input int ds);
      if (ds != 0) return (iq >= 10) ? pat[1] : 7'h00;
      return pat[iq % 10];
   endfunction

   task automatic model(input bit r, input int v);
      int d, dsa, dsb;
      bit down;
      if (r) begin
         m_n = 0; m_valid = 0; m_iq = 0;
         m_stepped = 0; m_dir = 0; m_hold = 0; m_turns = 0; m_err = 0;
         e_seg_a = 7'h00; e_an_a = 2'b00;
         e_seg_b = 7'h7F; e_an_b = 2'b11;
      end else begin
         dsa = (m_n / DIV_A) % 2;
         dsb = (m_n / DIV_B) % 2;
         e_seg_a = digit_seg(m_iq, dsa);
         e_an_a  = (dsa != 0) ? 2'b10 : 2'b01;
         e_seg_b = ~digit_seg(m_iq, dsb);
         e_an_b  = (dsb != 0) ? 2'b01 : 2'b10;
         m_n++;
         m_hold = 0;
         if (m_valid) begin
            d = (v - m_iq + 16) % 16;
            if (d == 0) m_hold = 1;
            else if (d == 1 || d == 15) begin
               down = (d == 15);
               if (!m_stepped) begin
                  m_stepped = 1; m_dir = down;
               end else if (down != m_dir) begin
                  m_dir = down;
                  if (m_turns < 255) m_turns++;
               end
            end else m_err = 1;
         end
         m_valid = 1;
         m_iq = v;
      end
   endtask

   task automatic compare();
      chk("SEG_a", SEG_a, e_seg_a);
      chk("AN_a", AN_a, e_an_a);
      chk("SEG_b", SEG_b, e_seg_b);
      chk("AN_b", AN_b, e_an_b);
      chk("DIR_a", DIR_a, m_dir);
      chk("DIR_b", DIR_b, m_dir);
      chk("HOLD_a", HOLD_a, m_hold);
      chk("HOLD_b", HOLD_b, m_hold);
      chk("TURNS_a", TURNS_a, m_turns);
      chk("TURNS_b", TURNS_b, m_turns);
      chk("ERR_a", ERR_a, m_err);
      chk("ERR_b", ERR_b, m_err);
   endtask

   task automatic step(input bit r, input int v);
      @(negedge CLK);
      R = r;
      I = v[3:0];
      @(posedge CLK);
      model(r, v);
      #1;
      compare();
   endtask

   initial begin
      int cur, sel;

      // reset
      step(1, 5);
      step(1, 3);
      chk("rst_seg_a", SEG_a, 7'h00);
      chk("rst_an_a", AN_a, 2'b00);
      chk("rst_seg_b", SEG_b, 7'h7F);
      chk("rst_an_b", AN_b, 2'b11);
      chk("rst_turns", TURNS_a, 8'd0);

      // full sweep 0..15,15..0,0,1
      for (int v = 0; v <= 15; v++) step(0, v);
      chk("sweep_up_dir", DIR_a, 1'b0);
      step(0, 15);
      chk("sweep_hold15", HOLD_a, 1'b1);
      step(0, 14);
      chk("sweep_rev1_dir", DIR_a, 1'b1);
      chk("sweep_rev1_turns", TURNS_a, 8'd1);
      chk("sweep_hold_clr", HOLD_a, 1'b0);
      for (int v = 13; v >= 0; v--) step(0, v);
      step(0, 0);
      chk("sweep_hold0", HOLD_a, 1'b1);
      step(0, 1);
      chk("sweep_rev2_dir", DIR_a, 1'b0);
      chk("sweep_rev2_turns", TURNS_a, 8'd2);
      chk("sweep_err", ERR_a, 1'b0);

      // illegal jump 3 -> 7
      step(0, 2);
      step(0, 3);
      step(0, 7);
      chk("jump_err", ERR_a, 1'b1);
      chk("jump_dir", DIR_a, 1'b0);
      chk("jump_turns", TURNS_a, 8'd2);
      step(0, 8);
      step(0, 8);
      chk("jump_sticky", ERR_b, 1'b1);
      step(1, 8);
      chk("jump_rst_err", ERR_a, 1'b0);

      // display scan with 13
      for (int k = 0; k < 24; k++) begin
         step(0, 13);
         if (k >= 2) begin
            if (AN_a == 2'b01) chk("scan_units_a", SEG_a, 7'h4F);
            else if (AN_a == 2'b10) chk("scan_tens_a", SEG_a, 7'h06);
            else chk("scan_an_a", AN_a, 2'b01);
            if (AN_b == 2'b10) chk("scan_units_b", SEG_b, 7'h30);
            else if (AN_b == 2'b01) chk("scan_tens_b", SEG_b, 7'h79);
            else chk("scan_an_b", AN_b, 2'b10);
         end
      end

      // blanking with 7
      step(1, 0);
      for (int k = 0; k < 20; k++) begin
         step(0, 7);
         if (k >= 2) begin
            if (AN_a == 2'b01) chk("blank_units_a", SEG_a, 7'h07);
            else if (AN_a == 2'b10) chk("blank_tens_a", SEG_a, 7'h00);
            else chk("blank_an_a", AN_a, 2'b01);
            if (AN_b == 2'b01) chk("blank_tens_b", SEG_b, 7'h7F);
         end
      end

      // saturation: 300 reversals
      step(1, 0);
      for (int k = 0; k < 302; k++) step(0, (k % 2 != 0) ? 6 : 5);
      chk("sat_turns", TURNS_a, 8'd255);
      chk("sat_dir", DIR_a, 1'b0);
      step(0, 5);
      chk("sat_dir_toggle", DIR_a, 1'b1);
      chk("sat_turns_hold", TURNS_b, 8'd255);

      // mid-sweep reset at 9
      step(1, 0);
      step(0, 12);
      step(0, 11);
      step(0, 10);
      step(1, 9);
      chk("mid_rst_dir", DIR_a, 1'b0);
      chk("mid_rst_turns", TURNS_a, 8'd0);
      chk("mid_rst_seg", SEG_a, 7'h00);
      chk("mid_rst_an_b", AN_b, 2'b11);
      step(0, 9);
      chk("mid_prime_hold", HOLD_a, 1'b0);
      chk("mid_prime_err", ERR_a, 1'b0);
      step(0, 8);
      chk("mid_first_dir", DIR_a, 1'b1);
      chk("mid_first_turns", TURNS_a, 8'd0);

      // random stream: mostly steps and holds, some jumps and resets
      cur = 8;
      for (int k = 0; k < 3000; k++) begin
         sel = $urandom_range(0, 99);
         if (sel < 2) begin
            step(1, $urandom_range(0, 15));
            continue;
         end else if (sel < 40) cur = (cur + 1) % 16;
         else if (sel < 75) cur = (cur + 15) % 16;
         else if (sel < 92) cur = cur;
         else cur = $urandom_range(0, 15);
         step(0, cur);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
